// File: rtl/cmp_code_decoder.sv
// Receiving end of the 2-bit compare code: handshake intake, one-hot g/e/l expansion,
// saturating per-result tallies, identical-result run length and a sticky illegal-code error.
//   state | meaning
//   IDLE  | no legal code held since reset/clear
//   RUN   | at least one legal code held; exactly one of g/e/l high
//   ERR   | illegal code seen; intake blocked until clear or rst
module cmp_code_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       code,
  output logic             out_valid,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic             err,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] run_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_last_code;
  logic             w_accept;
  logic             w_legal;
  logic [2:0]       w_gle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready = !rst && !clear && (r_state != ERR);
  assign w_accept = in_valid && in_ready;
  assign w_legal  = (code != 2'b11);

  always_comb begin
    w_gle = 3'b000;
    case (code)
      2'b01:   w_gle = 3'b100;
      2'b10:   w_gle = 3'b010;
      2'b00:   w_gle = 3'b001;
      default: w_gle = 3'b000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, RUN: if (w_accept) w_state_nxt = w_legal ? RUN : ERR;
        ERR:       w_state_nxt = ERR;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_code <= 2'b00;
      out_valid   <= 1'b0;
      {g, e, l}   <= 3'b000;
      err         <= 1'b0;
      gt_cnt      <= '0;
      eq_cnt      <= '0;
      lt_cnt      <= '0;
      run_len     <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_last_code <= 2'b00;
      out_valid   <= 1'b0;
      {g, e, l}   <= 3'b000;
      err         <= 1'b0;
      gt_cnt      <= '0;
      eq_cnt      <= '0;
      lt_cnt      <= '0;
      run_len     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      out_valid <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          out_valid   <= 1'b1;
          {g, e, l}   <= w_gle;
          r_last_code <= code;
          case (code)
            2'b01:   gt_cnt <= sat_inc(gt_cnt);
            2'b10:   eq_cnt <= sat_inc(eq_cnt);
            default: lt_cnt <= sat_inc(lt_cnt);
          endcase
          // A run restarts after IDLE even if the new code matches the stale last code.
          if (r_state == IDLE || code != r_last_code)
            run_len <= {{(CNT_W-1){1'b0}}, 1'b1};
          else
            run_len <= sat_inc(run_len);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_code_decoder.sv
// Directed bench for cmp_code_decoder with CNT_W=4 so saturation is reachable quickly.
module tb_cmp_code_decoder;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_ready;
  logic [1:0]       code;
  logic             out_valid, g, e, l, err;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, run_len;

  int n_checks = 0;
  int n_errors = 0;

  cmp_code_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .out_valid(out_valid), .g(g), .e(e), .l(l), .err(err),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .run_len(run_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; code = 2'b00;
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_gle", {29'd0, g, e, l}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnts", {gt_cnt, eq_cnt, lt_cnt, run_len}, 32'd0);
    chk("ready_idle", {31'd0, in_ready}, 32'd1);

    // T1: 01,10,00 back to back
    in_valid = 1'b1; code = 2'b01; tick();
    chk("t1_gle0", {29'd0, g, e, l}, 32'b100);
    chk("t1_ov0", {31'd0, out_valid}, 32'd1);
    code = 2'b10; tick();
    chk("t1_gle1", {29'd0, g, e, l}, 32'b010);
    chk("t1_ov1", {31'd0, out_valid}, 32'd1);
    code = 2'b00; tick();
    chk("t1_gle2", {29'd0, g, e, l}, 32'b001);
    chk("t1_ov2", {31'd0, out_valid}, 32'd1);
    chk("t1_cnts", {16'd0, gt_cnt, eq_cnt, lt_cnt, run_len}, 32'h1111);
    in_valid = 1'b0; tick();
    chk("t1_ov_low", {31'd0, out_valid}, 32'd0);
    chk("t1_hold_gle", {29'd0, g, e, l}, 32'b001);

    // T2: 20 consecutive equal codes saturate at 15
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; code = 2'b10;
    for (int i = 0; i < 14; i++) tick();
    chk("t2_eq14", {28'd0, eq_cnt}, 32'd14);
    chk("t2_run14", {28'd0, run_len}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("t2_eq_sat", {28'd0, eq_cnt}, 32'd15);
    chk("t2_run_sat", {28'd0, run_len}, 32'd15);
    chk("t2_gt_lt", {24'd0, gt_cnt, lt_cnt}, 32'd0);
    in_valid = 1'b0;

    // T3: 01,01,11,00
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; code = 2'b01; tick();
    tick();
    chk("t3_run2", {28'd0, run_len}, 32'd2);
    code = 2'b11; tick();
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_ov_illegal", {31'd0, out_valid}, 32'd0);
    chk("t3_ready", {31'd0, in_ready}, 32'd0);
    code = 2'b00; tick();
    chk("t3_gt", {28'd0, gt_cnt}, 32'd2);
    chk("t3_lt", {28'd0, lt_cnt}, 32'd0);
    chk("t3_gle", {29'd0, g, e, l}, 32'b100);
    chk("t3_ov_blocked", {31'd0, out_valid}, 32'd0);
    chk("t3_run_held", {28'd0, run_len}, 32'd2);

    // T4: clear from ERR with a code presented
    clear = 1'b1; code = 2'b00; #1;
    chk("t4_ready_clr", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0; #1;
    chk("t4_err", {31'd0, err}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_gle", {29'd0, g, e, l}, 32'd0);
    chk("t4_cnts", {gt_cnt, eq_cnt, lt_cnt, run_len}, 32'd0);
    chk("t4_ov", {31'd0, out_valid}, 32'd0);

    // T5: valid 1,0,1 with code 00
    in_valid = 1'b1; code = 2'b00; tick();
    chk("t5_ov0", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; tick();
    chk("t5_ov1", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; tick();
    chk("t5_ov2", {31'd0, out_valid}, 32'd1);
    chk("t5_lt", {28'd0, lt_cnt}, 32'd2);
    chk("t5_run", {28'd0, run_len}, 32'd2);
    code = 2'b01; tick();
    chk("t5_run_restart", {28'd0, run_len}, 32'd1);

    // T6: rst with clear and valid mid-stream
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; code = 2'b10; #1;
    chk("t6_ready_rst", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("t6_gle", {29'd0, g, e, l}, 32'd0);
    chk("t6_ov_err", {30'd0, out_valid, err}, 32'd0);
    chk("t6_cnts", {gt_cnt, eq_cnt, lt_cnt, run_len}, 32'd0);
    chk("t6_ready_hold", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("t6_ready_rel", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
